// File: rtl/mem_responder.sv
// Memory-mapped responder: word RAM, free-running timer and a light-gun trigger FIFO
// behind a single request/ready handshake. Define MEM_WAIT_STATE_EN to add a WAIT state.
module mem_responder #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] readData,
  output logic             ready,
  input  logic             trig_valid,
  input  logic [7:0]       trig_data
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [WIDTH-1:0] ADDR_TIMER  = WIDTH'(16'hFFF0);
  localparam logic [WIDTH-1:0] ADDR_POP    = WIDTH'(16'hFFF1);
  localparam logic [WIDTH-1:0] ADDR_STATUS = WIDTH'(16'hFFF2);

`ifdef MEM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
`endif

  state_t           state, state_next;
  logic [WIDTH-1:0] addr_q, wdata_q, acc_data;
  logic             we_q;
  logic [15:0]      timer;
  logic [WIDTH-1:0] ram [RAM_DEPTH];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;

  logic          is_ram, is_tmr, is_pop, is_stat, access;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok, drop, ram_we, tmr_we, ovf_clr;
  logic [AW-1:0] ram_idx;

  // Address decode and per-target strobes, all qualified by the ACCESS cycle
  assign is_ram     = addr_q < WIDTH'(RAM_DEPTH);
  assign is_tmr     = addr_q == ADDR_TIMER;
  assign is_pop     = addr_q == ADDR_POP;
  assign is_stat    = addr_q == ADDR_STATUS;
  assign ram_idx    = addr_q[AW-1:0];
  assign access     = state == ACCESS;
  assign fifo_empty = count == '0;
  assign fifo_full  = count == CW'(FIFO_DEPTH);
  assign pop        = access && !we_q && is_pop && !fifo_empty;
  assign push_ok    = trig_valid && (!fifo_full || pop);
  assign drop       = trig_valid && fifo_full && !pop;
  assign ram_we     = access && we_q && is_ram;
  assign tmr_we     = access && we_q && is_tmr;
  assign ovf_clr    = access && we_q && is_stat;

  // Read data selected during ACCESS
  always_comb begin
    acc_data = '0;
    if (!we_q) begin
      if (is_ram) begin
        acc_data = ram[ram_idx];
      end else if (is_tmr) begin
        acc_data = WIDTH'(timer);
      end else if (is_pop) begin
        acc_data = fifo_empty ? '0 : WIDTH'({7'b0, 1'b1, fifo_mem[rd_ptr]});
      end else if (is_stat) begin
        acc_data = WIDTH'({13'b0, overflow, fifo_full, fifo_empty});
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (req) state_next = ACCESS;
`ifdef MEM_WAIT_STATE_EN
      ACCESS: state_next = WAIT;
      WAIT:   state_next = RESP;
`else
      ACCESS: state_next = RESP;
`endif
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (state == IDLE && req) begin
      addr_q  <= addr;
      wdata_q <= writeData;
      we_q    <= we;
    end
  end

  // RAM contents survive reset; reset only blocks a write on the same edge
  always_ff @(posedge clk) begin
    if (!reset && ram_we) ram[ram_idx] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset)       timer <= '0;
    else if (tmr_we) timer <= 16'(wdata_q);
    else             timer <= timer + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_mem[wr_ptr] <= trig_data;
  end

  // Overflow set by a dropped push wins over a same-edge clear
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FW'(1);
      if (pop)     rd_ptr <= rd_ptr + FW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef MEM_WAIT_STATE_EN
  logic [WIDTH-1:0] hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold     <= '0;
      ready    <= 1'b0;
      readData <= '0;
    end else begin
      if (access) hold <= acc_data;
      ready    <= state_next == RESP;
      readData <= (state_next == RESP) ? hold : '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ready    <= 1'b0;
      readData <= '0;
    end else begin
      ready    <= state_next == RESP;
      readData <= (state_next == RESP) ? acc_data : '0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected responses are queued at request time and
// popped on each ready pulse; data and latency are both compared.
module tb_mem_responder;

`ifdef MEM_WAIT_STATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset, req, we, ready, trig_valid;
  logic [15:0] addr, writeData, readData;
  logic [7:0]  trig_data;

  mem_responder dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .writeData(writeData), .readData(readData), .ready(ready),
    .trig_valid(trig_valid), .trig_data(trig_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   pulses = 0, double_cnt = 0, zero_viol = 0;
  bit   free_mode = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        pulses++;
        if (free_mode) begin
          check("hold_data", 32'(readData), 32'h0000BEEF);
        end else begin
          check("ready_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) check("read_data", 32'(readData), 32'(e.data));
            check("latency", 32'(cyc), 32'(e.cyc));
          end
        end
      end else if (readData !== 16'h0000) begin
        zero_viol++;
      end
      if (ready === 1'b1 && prev_ready === 1'b1) double_cnt++;
    end
    prev_ready = ready;
  end

  // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic chk, input logic [15:0] exp,
                        input logic trig_in, input logic [7:0] tdat);
    int n;
    req = 1'b1; we = w; addr = a; writeData = d;
    @(posedge clk); #1;
    n = cyc;
    sb.push_back('{chk, exp, n + LAT - 1});
    @(negedge clk);
    req = 1'b0;
    if (trig_in) begin trig_valid = 1'b1; trig_data = tdat; end
    @(negedge clk);
    trig_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp);
    access(1'b0, a, 16'h0, 1'b1, exp, 1'b0, 8'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    access(1'b1, a, d, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic trig(input logic [7:0] d);
    trig_valid = 1'b1; trig_data = d;
    @(negedge clk);
    trig_valid = 1'b0;
  endtask

  logic [15:0] ram_addr [4] = '{16'h0000, 16'h0001, 16'h0200, 16'h03FF};
  logic [15:0] ram_data [4];
  int p0, win, total;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; writeData = '0;
    trig_valid = 1'b0; trig_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", 32'(readData), 32'd0);
    reset = 1'b0;
    rd(16'hFFF2, 16'h0001);

    // RAM write/read, including both ends of the RAM window
    wr(16'h0010, 16'hBEEF);
    rd(16'h0010, 16'hBEEF);
    foreach (ram_addr[i]) begin
      ram_data[i] = 16'($urandom);
      wr(ram_addr[i], ram_data[i]);
    end
    foreach (ram_addr[i]) rd(ram_addr[i], ram_data[i]);
    rd(16'h0400, 16'h0000);

    // Unmapped address
    rd(16'h8000, 16'h0000);
    wr(16'h8000, 16'h5555);
    rd(16'h8000, 16'h0000);
    rd(16'h0010, 16'hBEEF);
    rd(16'hFFF2, 16'h0001);

    // FIFO fill past full, drain past empty, clear overflow
    for (int i = 1; i <= 5; i++) trig(8'(i * 8'h11));
    rd(16'hFFF2, 16'h0006);
    for (int i = 1; i <= 4; i++) rd(16'hFFF1, 16'h0100 | 16'(i * 8'h11));
    rd(16'hFFF1, 16'h0000);
    rd(16'hFFF2, 16'h0005);
    wr(16'hFFF2, 16'h0000);
    rd(16'hFFF2, 16'h0001);

    // Push and pop on the same edge while full
    for (int i = 0; i < 4; i++) trig(8'(8'hA0 + i));
    rd(16'hFFF2, 16'h0002);
    access(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h01A0, 1'b1, 8'hA4);
    rd(16'hFFF2, 16'h0002);
    for (int i = 1; i <= 4; i++) rd(16'hFFF1, 16'h0100 | 16'(8'hA0 + i));
    rd(16'hFFF2, 16'h0001);

    // Push and pop on the same edge while empty
    access(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0000, 1'b1, 8'hB0);
    rd(16'hFFF2, 16'h0000);
    rd(16'hFFF1, 16'h01B0);

    // Overflow clear loses to a dropped push on the same edge
    for (int i = 0; i < 4; i++) trig(8'(8'hC0 + i));
    access(1'b1, 16'hFFF2, 16'h0, 1'b0, 16'h0, 1'b1, 8'hC4);
    rd(16'hFFF2, 16'h0006);
    rd(16'hFFF1, 16'h01C0);

    // Timer wrap: next read is sampled LAT+1 edges after the write
    wr(16'hFFF0, 16'hFFFE);
    rd(16'hFFF0, 16'hFFFE + 16'(LAT));

    // req held high for 9 edges
    free_mode = 1;
    p0 = pulses;
    req = 1'b1; we = 1'b0; addr = 16'h0010;
    repeat (9) @(negedge clk);
    #1;
    win = pulses - p0;
    req = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    total = pulses - p0;
    free_mode = 0;
    check("hold_window_pulses", 32'(win), (LAT == 2) ? 32'd3 : 32'd2);
    check("hold_total_pulses", 32'(total), 32'd3);

    // Reset on the ACCESS edge of a RAM write aborts it
    wr(16'h0005, 16'h0A0A);
    trig(8'hD0);
    req = 1'b1; we = 1'b1; addr = 16'h0005; writeData = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; reset = 1'b1; p0 = pulses;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("abort_no_ready", 32'(pulses - p0), 32'd0);
    rd(16'h0005, 16'h0A0A);
    rd(16'hFFF2, 16'h0001);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("ready_one_cycle", 32'(double_cnt), 32'd0);
    check("rdata_zero_idle", 32'(zero_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: WIDTH, 16, data/address width in bits.
REQ-002 Parameter: RAM_DEPTH, 1024, RAM words, power of two, at most 32768.
REQ-003 Parameter: FIFO_DEPTH, 4, trigger-event FIFO entries, power of two.
REQ-004 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req  input  1  access request from the processor, sampled in IDLE only.
REQ-007 Port: we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 Port: addr  input  WIDTH  word address; sampled with req.
REQ-009 Port: writeData  input  WIDTH  store data; sampled with req.
REQ-010 Port: readData  output  WIDTH  load data; valid only while ready=1.
REQ-011 Port: ready  output  1  one-cycle completion pulse for reads and writes.
REQ-012 Port: trig_valid  input  1  one-cycle light-gun event strobe.
REQ-013 Port: trig_data  input  8  event payload pushed with trig_valid.

Function
REQ-014 FSM states: IDLE, ACCESS, WAIT (present only with the macro enabled), RESP.
REQ-015 IDLE: if req=1 at the edge, latch addr/we/writeData and go to ACCESS; otherwise stay in IDLE.
REQ-016 ACCESS: perform the decoded access, then go to RESP (or to WAIT with the macro enabled).
REQ-017 RESP: ready=1 and readData driven for exactly one cycle, then go to IDLE.
REQ-018 req outside IDLE is ignored and not queued; back-to-back requests therefore cost 3 cycles each (4 with the macro).
REQ-019 Latency: with req sampled at edge N, ready=1 during cycle N+2 (N+3 with the macro).
REQ-020 Decode, addr < RAM_DEPTH: synchronous RAM word at addr; a write commits at the ACCESS edge.
REQ-021 Decode, 0xFFF0: timer; read returns the free-running 16-bit counter (+1 per clk, wraps 0xFFFF -> 0x0000); write loads writeData.
REQ-022 Decode, 0xFFF1: FIFO pop; read returns {7'b0, nonempty, head[7:0]} and pops if nonempty; an empty read returns 0 and does not pop; writes are ignored.
REQ-023 Decode, 0xFFF2: status; read returns {13'b0, overflow, full, empty}; any write clears overflow.
REQ-024 Decode, all other addresses: reads return 0, writes are discarded, ready still pulses.
REQ-025 FIFO push on trig_valid=1 in any state; push when full drops the event and sets overflow (sticky).
REQ-026 Push and pop in the same cycle: both occur and count is unchanged, including when full; when empty, only the push occurs and the pop read returns 0.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-028 An overflow-clear write and a dropped push in the same cycle leave overflow=1.
REQ-029 readData=0 whenever ready=0.

Reset
REQ-030 reset=1 forces: state IDLE, ready=0, readData=0, FIFO empty, overflow=0, timer=0.
REQ-031 reset has priority over all activity: a RAM/timer write or pop in the same edge as reset does not commit, and no ready is issued for an aborted access.
REQ-032 RAM contents are not affected by reset.

Configuration
REQ-033 Macro MEM_WAIT_STATE_EN defined: the WAIT state is inserted between ACCESS and RESP, giving latency N+3.
REQ-034 Macro MEM_WAIT_STATE_EN undefined: the WAIT state is absent, latency is N+2, and there is no other functional difference.

Verification
REQ-035 Write addr 0x0010 = 0xBEEF, then read 0x0010 -> readData 0xBEEF with ready at N+2 (N+3 with the macro).
REQ-036 Push 0x11, 0x22, 0x33, 0x44, 0x55 with FIFO_DEPTH=4 -> status reads 0x0006 (overflow=1, full=1); pop reads return 0x0111, 0x0122, 0x0133, 0x0144, then 0x0000.
REQ-037 Hold req=1 continuously for 9 cycles -> exactly 3 ready pulses (2 with the macro), each one cycle wide.
REQ-038 Write 0xFFF0 = 0xFFFE, then read 0xFFF0 two cycles later -> the counter has wrapped through 0x0000 as expected.
REQ-039 Assert reset at the ACCESS edge of a write of 0x1234 to addr 0x0005 -> no ready pulse, RAM[5] unchanged, state IDLE.
REQ-040 Read 0x8000 -> readData 0x0000 with a ready pulse; write 0x8000 -> no RAM or register change.
